// File: rtl/deser_align.sv
// Receive-side 1:WIDTH deserializer: finds word alignment from an all-ones sync word
// that follows a zero, then emits LSB-first words through a one-entry valid/ready buffer.
//
// state  | meaning
// SEARCH | waiting for a 0 -> 1 transition that starts a sync word
// SYNC   | counting consecutive ones; WIDTH of them give alignment
// LOCKED | aligned, shifting data words in and handing them to the buffer
module deser_align #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             din,
  input  logic             align_req,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             locked,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {SEARCH, SYNC, LOCKED} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] word;
  logic             prev_q;
  logic             word_done;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= SEARCH;
      cnt_q   <= '0;
      sr_q    <= '0;
      prev_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      prev_q  <= din;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    word_done = 1'b0;
    word      = {din, sr_q[WIDTH-2:0]};
    if (align_req) begin
      state_d = SEARCH;
      cnt_d   = '0;
      sr_d    = '0;
    end else begin
      case (state_q)
        SEARCH: begin
          // a sync word only counts if it is preceded by a zero
          if (din && !prev_q) begin
            state_d = SYNC;
            cnt_d   = CW'(1);
          end
        end
        SYNC: begin
          if (!din) begin
            state_d = SEARCH;
            cnt_d   = '0;
          end else if (cnt_q == LAST) begin
            state_d = LOCKED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        LOCKED: begin
          for (int i = 0; i < WIDTH; i++) begin
            if (cnt_q == CW'(i)) sr_d[i] = din;
          end
          if (cnt_q == LAST) begin
            word_done = 1'b1;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = SEARCH;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign locked = (state_q == LOCKED);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (word_done && (!dout_valid || dout_ready)) begin
        dout       <= word;
        dout_valid <= 1'b1;
      end else if (word_done) begin
        overflow <= 1'b1;
      end else if (dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_deser_align.sv
// Directed bench for deser_align at WIDTH=8: sync detection, buffering,
// backpressure/overflow, align_req and a random word stream.
module tb_deser_align;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rstb;
  logic         din;
  logic         align_req;
  logic [W-1:0] dout;
  logic         dout_valid;
  logic         dout_ready;
  logic         locked;
  logic         overflow;

  int errors = 0;
  int checks = 0;

  deser_align #(.WIDTH(W)) dut (
    .clk        (clk),
    .rstb       (rstb),
    .din        (din),
    .align_req  (align_req),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .locked     (locked),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    din = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) send_bit(w[i]);
  endtask

  task automatic send_ones(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  logic [W-1:0] rw;

  initial begin
    rstb = 1'b0; din = 1'b0; align_req = 1'b0; dout_ready = 1'b0;
    #12;
    check("rst_locked", 32'(locked), 0);
    check("rst_valid", 32'(dout_valid), 0);
    check("rst_dout", 32'(dout), 0);
    check("rst_ovf", 32'(overflow), 0);
    rstb = 1'b1;
    @(posedge clk); #1;

    // basic sync then 0xA5
    dout_ready = 1'b1;
    send_bit(0); send_bit(0); send_bit(0);
    send_ones(7);
    check("t2_not_locked_7", 32'(locked), 0);
    send_bit(1);
    check("t2_locked_8", 32'(locked), 1);
    for (int i = 0; i < W - 1; i++) send_bit(rw_bit(8'hA5, i));
    check("t2_valid_before_last", 32'(dout_valid), 0);
    send_bit(1'b1);
    check("t2_valid", 32'(dout_valid), 1);
    check("t2_dout", 32'(dout), 32'hA5);

    // async reset mid-LOCKED with a buffered word
    rstb = 1'b0;
    #1;
    check("t1_locked", 32'(locked), 0);
    check("t1_valid", 32'(dout_valid), 0);
    check("t1_dout", 32'(dout), 0);
    check("t1_ovf", 32'(overflow), 0);
    @(posedge clk); #1;
    rstb = 1'b1;

    // false sync: five ones broken by a zero
    send_bit(0);
    send_ones(5);
    check("t3_sync5_not_locked", 32'(locked), 0);
    send_bit(0);
    check("t3_zero_not_locked", 32'(locked), 0);
    send_ones(7);
    check("t3_sync7_not_locked", 32'(locked), 0);
    send_bit(1);
    check("t3_locked", 32'(locked), 1);
    send_word(8'h3C);
    check("t3_valid", 32'(dout_valid), 1);
    check("t3_dout", 32'(dout), 32'h3C);

    // backpressure: 0x3C drains on bit 0 of 0x11, then ready drops
    send_bit(1'b1);
    check("t4_drain", 32'(dout_valid), 0);
    dout_ready = 1'b0;
    for (int i = 1; i < W; i++) send_bit(rw_bit(8'h11, i));
    check("t4_valid_11", 32'(dout_valid), 1);
    check("t4_dout_11", 32'(dout), 32'h11);
    check("t4_ovf_clear", 32'(overflow), 0);
    send_word(8'h22);
    check("t4_dout_held", 32'(dout), 32'h11);
    check("t4_valid_held", 32'(dout_valid), 1);
    check("t4_ovf_set", 32'(overflow), 1);
    dout_ready = 1'b1;
    send_bit(1'b1);
    check("t4_consumed", 32'(dout_valid), 0);

    // align_req at bit 3 of the current word
    send_bit(0); send_bit(1);
    align_req = 1'b1;
    send_bit(0);
    align_req = 1'b0;
    check("t5_unlocked", 32'(locked), 0);
    for (int i = 4; i < W; i++) send_bit(1'b1);
    check("t5_no_word", 32'(dout_valid), 0);
    check("t5_still_unlocked", 32'(locked), 0);
    send_bit(0);
    send_ones(W);
    check("t5_relocked", 32'(locked), 1);
    send_word(8'h96);
    check("t5_valid", 32'(dout_valid), 1);
    check("t5_dout", 32'(dout), 32'h96);
    check("t5_ovf_sticky", 32'(overflow), 1);

    // random stream
    rstb = 1'b0;
    #1;
    rstb = 1'b1;
    send_bit(0);
    send_ones(W);
    check("t6_locked", 32'(locked), 1);
    for (int n = 0; n < 64; n++) begin
      rw = W'($urandom);
      for (int i = 0; i < W - 1; i++) begin
        send_bit(rw[i]);
        check("t6_gap", 32'(dout_valid), 0);
      end
      send_bit(rw[W-1]);
      check("t6_valid", 32'(dout_valid), 1);
      check("t6_dout", 32'(dout), 32'(rw));
    end
    check("t6_ovf", 32'(overflow), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  function automatic logic rw_bit(input logic [W-1:0] w, input int i);
    return w[i];
  endfunction

endmodule
